// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM
// state encoding and the default datapath width.
package hilo_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIX   = 3'd3,
        WRITE = 3'd4
    } state_t;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the HI/LO datapath: shift-add multiply (mode=0) or
// restoring divide (mode=1) on a {hi, lo} double-width accumulator.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic           mode,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] acc_next
);

    logic [W:0]   sum;
    logic [W:0]   rem_sh;
    logic [W-1:0] rem_sub;
    logic         fits;

    always_comb begin
        sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
        rem_sh  = acc[2*W-1:W-1];
        fits    = rem_sh >= {1'b0, operand};
        // When the divisor fits, the true difference is below 2^W, so a
        // W-bit subtraction is exact.
        rem_sub = rem_sh[W-1:0] - operand;
        if (mode) begin
            acc_next = fits ? {rem_sub, acc[W-2:0], 1'b1}
                            : {rem_sh[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[W-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: accepts MULT/DIV/MTHI/MTLO, iterates on magnitudes, fixes
// signs, then drives one write cycle into the external HI/LO registers.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = hilo_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             hi_w,
    output logic             lo_w,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data
);
    import hilo_pkg::*;

    localparam int CW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [2:0]         op_q, op_d;
    logic               sign_quo_q, sign_quo_d, sign_rem_q, sign_rem_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic               hi_w_q, hi_w_d, lo_w_q, lo_w_d;
    logic [WIDTH-1:0]   hi_data_q, hi_data_d, lo_data_q, lo_data_d;

    logic [WIDTH-1:0]   mag_a, mag_b, acc_hi, acc_lo;
    logic               op_signed;

    muldiv_step #(.W(WIDTH)) u_step (
        .mode     (op_q[1]),
        .acc      (acc_q),
        .operand  (dvsr_q),
        .acc_next (acc_step)
    );

    always_comb begin
        op_signed   = is_signed_op(op);
        mag_a       = (op_signed && a[WIDTH-1]) ? -a : a;
        mag_b       = (op_signed && b[WIDTH-1]) ? -b : b;
        acc_hi      = acc_q[2*WIDTH-1:WIDTH];
        acc_lo      = acc_q[WIDTH-1:0];

        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        dvsr_d      = dvsr_q;
        op_d        = op_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = 1'b0;
        hi_w_d      = 1'b0;
        lo_w_d      = 1'b0;
        hi_data_d   = hi_data_q;
        lo_data_d   = lo_data_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && op <= OP_MTLO) begin
                    busy_d     = 1'b1;
                    op_d       = op;
                    cnt_d      = '0;
                    dvsr_d     = mag_b;
                    sign_quo_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sign_rem_d = op_signed & a[WIDTH-1];
                    // Short ops keep the raw source in both halves for WRITE.
                    acc_d      = {a, a};
                    if (op == OP_MULT || op == OP_MULTU) begin
                        state_d = MUL;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                    end else if ((op == OP_DIV || op == OP_DIVU) && b != '0) begin
                        state_d = DIV;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            MUL, DIV: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (op_q[1]) begin
                    acc_d = {sign_rem_q ? -acc_hi : acc_hi, sign_quo_q ? -acc_lo : acc_lo};
                end else if (sign_quo_q) begin
                    acc_d = -acc_q;
                end
                state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_MTHI: begin
                        hi_w_d    = 1'b1;
                        hi_data_d = acc_hi;
                    end
                    OP_MTLO: begin
                        lo_w_d    = 1'b1;
                        lo_data_d = acc_lo;
                    end
                    default: begin
                        hi_w_d    = 1'b1;
                        lo_w_d    = 1'b1;
                        hi_data_d = acc_hi;
                        lo_data_d = acc_lo;
                        if (op_q[1] && dvsr_q == '0) begin
                            dbz_d     = 1'b1;
                            lo_data_d = '1;
                        end
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            dvsr_q     <= '0;
            op_q       <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_w_q     <= 1'b0;
            lo_w_q     <= 1'b0;
            hi_data_q  <= '0;
            lo_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dvsr_q     <= dvsr_d;
            op_q       <= op_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            hi_w_q     <= hi_w_d;
            lo_w_q     <= lo_w_d;
            hi_data_q  <= hi_data_d;
            lo_data_q  <= lo_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi_w        = hi_w_q;
    assign lo_w        = lo_w_q;
    assign hi_data     = hi_data_q;
    assign lo_data     = lo_data_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed vector table, corner
// sequences, and random ops against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;
    import hilo_pkg::*;

    logic        clk, rst, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero, hi_w, lo_w;
    logic [31:0] hi_data, lo_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi_w(hi_w), .lo_w(lo_w), .hi_data(hi_data), .lo_data(lo_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        hw, lw, dz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; HI/LO output registers hold between writes.
    task automatic model(input logic [2:0] o, input logic [31:0] aa, bb,
                         output logic [31:0] eh, el, output logic ehw, elw, edz,
                         output int elat);
        longint      sa, sb, q, r;
        logic [63:0] r64, q64, rr64;
        sa = longint'($signed(aa));
        sb = longint'($signed(bb));
        ehw = 0; elw = 0; edz = 0; elat = 1;
        case (o)
            OP_MULT, OP_MULTU: begin
                if (o == OP_MULT) r64 = sa * sb;
                else              r64 = {32'b0, aa} * {32'b0, bb};
                m_hi = r64[63:32]; m_lo = r64[31:0];
                ehw = 1; elw = 1; elat = 34;
            end
            OP_DIV, OP_DIVU: begin
                ehw = 1; elw = 1;
                if (bb == 0) begin
                    m_hi = aa; m_lo = 32'hFFFF_FFFF; edz = 1;
                end else begin
                    if (o == OP_DIV) begin
                        q = sa / sb; r = sa % sb;
                    end else begin
                        q = longint'({32'b0, aa}) / longint'({32'b0, bb});
                        r = longint'({32'b0, aa}) % longint'({32'b0, bb});
                    end
                    q64 = q; rr64 = r;
                    m_lo = q64[31:0]; m_hi = rr64[31:0];
                    elat = 34;
                end
            end
            OP_MTHI: begin m_hi = aa; ehw = 1; end
            OP_MTLO: begin m_lo = aa; elw = 1; end
            default: ;
        endcase
        eh = m_hi; el = m_lo;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] aa, bb,
                         output int lat, output logic bsy,
                         output logic [31:0] hd, ld, output logic hw, lw, dz,
                         output int early_w);
        @(negedge clk);
        start = 1; op = o; a = aa; b = bb;
        @(posedge clk); #1;
        start = 0;
        bsy = busy;
        lat = -1; early_w = 0;
        hd = 'x; ld = 'x; hw = 0; lw = 0; dz = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k; hd = hi_data; ld = lo_data;
                hw = hi_w; lw = lo_w; dz = div_by_zero;
                break;
            end
            if (hi_w || lo_w) early_w++;
        end
    endtask

    task automatic exec(input string tag, input logic [2:0] o, input logic [31:0] aa, bb,
                        input logic [31:0] eh, el, input logic ehw, elw, edz,
                        input int elat, input bit chk_idle);
        int lat, early_w; logic bsy, hw, lw, dz; logic [31:0] hd, ld;
        do_op(o, aa, bb, lat, bsy, hd, ld, hw, lw, dz, early_w);
        chk({tag, ".busy_after_accept"}, 64'(bsy), 64'(1));
        chk({tag, ".latency"}, 64'(lat), 64'(elat));
        chk({tag, ".hi_data"}, 64'(hd), 64'(eh));
        chk({tag, ".lo_data"}, 64'(ld), 64'(el));
        chk({tag, ".hi_w"}, 64'(hw), 64'(ehw));
        chk({tag, ".lo_w"}, 64'(lw), 64'(elw));
        chk({tag, ".div_by_zero"}, 64'(dz), 64'(edz));
        chk({tag, ".early_writes"}, 64'(early_w), 64'(0));
        if (chk_idle) begin
            @(posedge clk); #1;
            chk({tag, ".busy_low_after"}, 64'(busy), 64'(0));
            chk({tag, ".done_pulse_end"}, 64'(done), 64'(0));
        end
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] eh, el; logic ehw, elw, edz; int elat;
        int wcnt, lat, dcnt;

        rst = 1; start = 0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.hi_data", 64'(hi_data), 64'(0));
        chk("reset.lo_data", 64'(lo_data), 64'(0));
        @(negedge clk) rst = 0;
        #1;
        chk("reset.done", 64'(done), 64'(0));
        chk("reset.dbz", 64'(div_by_zero), 64'(0));
        chk("reset.we", 64'({hi_w, lo_w}), 64'(0));

        // Hand-computed expectations; data registers hold across ops.
        vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1, 1, 0, 34};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1, 1, 0, 34};
        vecs[2] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1, 1, 0, 34};
        vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1, 0, 34};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1, 1, 0, 34};
        vecs[5] = '{OP_DIVU,  32'h1234,      32'h0,        32'h1234,      32'hFFFF_FFFF, 1, 1, 1, 1};
        vecs[6] = '{OP_MTHI,  32'hCAFE_F00D, 32'h0,        32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 0, 0, 1};
        vecs[7] = '{OP_MTLO,  32'h5,         32'h0,        32'hCAFE_F00D, 32'h5,         0, 1, 0, 1};
        vecs[8] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1, 1, 0, 34};
        vecs[9] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1, 1, 0, 34};
        for (int i = 0; i < 10; i++)
            exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi,
                 vecs[i].lo, vecs[i].hw, vecs[i].lw, vecs[i].dz, vecs[i].lat, 1);
        m_hi = 32'h4000_0000; m_lo = 32'h0;

        // Back-to-back: DIVU accepted on the edge where busy falls.
        model(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, eh, el, ehw, elw, edz, elat);
        exec("b2b_mul", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1, 1, 0, 34, 0);
        model(OP_DIVU, 32'd100, 32'd7, eh, el, ehw, elw, edz, elat);
        exec("b2b_div", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1, 1, 0, 34, 1);

        // MTLO strobed while a multiply is running must be dropped.
        model(OP_MULT, 32'd3, 32'd4, eh, el, ehw, elw, edz, elat);
        @(negedge clk);
        start = 1; op = OP_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 0;
        wcnt = 0; lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin start = 1; op = OP_MTLO; a = 32'h77; end
            else start = 0;
            if (hi_w || lo_w) wcnt++;
            if (done) begin
                lat = k;
                chk("busy_mtlo.hi", 64'(hi_data), 64'(0));
                chk("busy_mtlo.lo", 64'(lo_data), 64'(12));
                break;
            end
        end
        start = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (hi_w || lo_w) wcnt++;
        end
        chk("busy_mtlo.latency", 64'(lat), 64'(34));
        chk("busy_mtlo.write_count", 64'(wcnt), 64'(1));

        // Illegal op code: stays idle, no pulses.
        @(negedge clk);
        start = 1; op = 3'b110; a = 32'hDEAD_BEEF; b = 32'h1;
        @(posedge clk); #1;
        start = 0;
        chk("illegal.busy", 64'(busy), 64'(0));
        dcnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || hi_w || lo_w) dcnt++;
        end
        chk("illegal.activity", 64'(dcnt), 64'(0));

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro; logic [31:0] ra, rb; int sel;
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            sel = $urandom_range(0, 7);
            rb = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
                 (sel == 2) ? 32'hFFFF_FFFF : $urandom;
            model(ro, ra, rb, eh, el, ehw, elw, edz, elat);
            exec($sformatf("rand%0d", i), ro, ra, rb, eh, el, ehw, elw, edz, elat, 1);
        end

        // Reset in the middle of a multiply aborts without writing.
        @(negedge clk);
        start = 1; op = OP_MULT; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("midrst.busy", 64'(busy), 64'(0));
        chk("midrst.hi_data", 64'(hi_data), 64'(0));
        chk("midrst.lo_data", 64'(lo_data), 64'(0));
        chk("midrst.we", 64'({hi_w, lo_w, done}), 64'(0));
        @(posedge clk); #1;
        chk("midrst.we_held", 64'({hi_w, lo_w}), 64'(0));
        @(negedge clk) rst = 0;
        m_hi = '0; m_lo = '0;
        exec("post_rst_mtlo", OP_MTLO, 32'h5, 32'h0, 32'h0, 32'h5, 0, 1, 0, 1, 1);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || hi_w || lo_w) dcnt++;
        end
        chk("midrst.no_stale_write", 64'(dcnt), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
